// File: rtl/pdp8_tt_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pdp8_tt_fifo : buffered KL8E-style console terminal with RX/TX FIFOs      |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module pdp8_tt_fifo #(
  parameter logic [5:0] RX_DEV    = 6'o03,
  parameter logic [5:0] TX_DEV    = 6'o04,
  parameter int         RX_AW     = 3,
  parameter int         TX_AW     = 3,
  parameter int         DATA_BITS = 8,
  parameter logic       IE_RESET  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iot,
  input  logic [3:0]           state,
  input  logic [11:0]          mb,
  input  logic [5:0]           io_select,
  input  logic [11:0]          io_data_in,
  output logic [11:0]          io_data_out,
  output logic                 io_selected,
  output logic                 io_skip,
  output logic                 io_data_avail,
  output logic                 io_interrupt,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_overrun,
  output logic                 tx_overrun
);

  localparam logic [3:0] F1 = 4'b0001;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int TX_DEPTH = 1 << TX_AW;

  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [RX_AW-1:0] rx_wr, rx_rd;
  logic [TX_AW-1:0] tx_wr, tx_rd;
  logic [RX_AW:0]   rx_count;
  logic [TX_AW:0]   tx_count;
  logic             ie, tx_flag;

  logic       fire_rx, fire_tx;
  logic [2:0] fn;
  logic       rx_empty, rx_full, tx_full, rx_flag;
  logic       rx_pop, rx_push, rx_drop;
  logic       tx_pop, tx_push_req, tx_push, tx_drop, tx_set, tx_clr, kie;
  logic [DATA_BITS-1:0] rx_head;
  logic [11:0] rx_head12;
  logic        unused_mb;

  assign fn        = mb[2:0];
  assign unused_mb = ^mb[11:3];
  assign fire_rx   = iot && (state == F1) && (io_select == RX_DEV);
  assign fire_tx   = iot && (state == F1) && (io_select == TX_DEV);

  assign rx_empty  = (rx_count == '0);
  assign rx_full   = (rx_count == RX_DEPTH[RX_AW:0]);
  assign tx_full   = (tx_count == TX_DEPTH[TX_AW:0]);
  assign rx_flag   = !rx_empty;
  assign rx_head   = rx_empty ? '0 : rx_mem[rx_rd];
  assign rx_head12 = {{(12-DATA_BITS){1'b0}}, rx_head};

  // A full FIFO still accepts a write when a pop frees the slot in the same cycle
  assign rx_pop      = fire_rx && fn[1] && !rx_empty;
  assign rx_push     = rx_valid && (!rx_full || rx_pop);
  assign rx_drop     = rx_valid && rx_full && !rx_pop;
  assign kie         = fire_rx && (fn == 3'd5);

  assign tx_valid    = (tx_count != '0);
  assign tx_data     = tx_mem[tx_rd];
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = fire_tx && fn[2] && (fn != 3'd5);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop     = tx_push_req && tx_full && !tx_pop;
  assign tx_set      = (fire_tx && (fn == 3'd0)) || tx_pop;
  assign tx_clr      = fire_tx && fn[1];

  assign io_selected   = fire_rx || fire_tx;
  assign io_data_avail = 1'b1;
  assign io_interrupt  = ie && (rx_flag || tx_flag);

  always_comb begin
    io_data_out = io_data_in;
    io_skip     = 1'b0;
    if (fire_rx) begin
      case (fn)
        3'd2, 3'd3:       io_data_out = 12'o0000;
        3'd4, 3'd6, 3'd7: io_data_out = rx_head12;
        default:          io_data_out = io_data_in;
      endcase
      io_skip = (fn == 3'd1) || (fn == 3'd3) || (fn == 3'd7) ? rx_flag : 1'b0;
    end else if (fire_tx) begin
      if ((fn == 3'd1) || (fn == 3'd3) || (fn == 3'd7))
        io_skip = !tx_full;
      else if (fn == 3'd5)
        io_skip = io_interrupt;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_data;
    if (tx_push) tx_mem[tx_wr] <= io_data_in[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_count   <= '0;
      tx_wr      <= '0;
      tx_rd      <= '0;
      tx_count   <= '0;
      ie         <= IE_RESET;
      tx_flag    <= 1'b0;
      rx_overrun <= 1'b0;
      tx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
      if (rx_drop) rx_overrun <= 1'b1;

      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_drop) tx_overrun <= 1'b1;

      // Set has priority so a handshake coinciding with TCF/TLS is not lost
      if (tx_set)      tx_flag <= 1'b1;
      else if (tx_clr) tx_flag <= 1'b0;

      if (kie) ie <= io_data_in[0];
    end
  end

endmodule
`default_nettype wire
